ldalign: RTL and testbench

Load alignment unit for the 32-bit core's data-memory read path. It accepts load requests (address, size, signedness), issues word-aligned reads to data memory, and tracks up to DEPTH outstanding loads in order. It buffers the returned words, then extracts the byte, half-word or word lane and zero- or sign-extends it. The result goes to the register write-back stage through a valid/ready handshake.

---
 rtl/ldalign.sv | 157 +++++++++++++++
 tb/tb_ldalign.sv | 552 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldalign.sv
// ldalign - load alignment unit for the data-memory read path.
//
// Accepts load requests, issues word-aligned read commands to data memory,
// keeps per-load attributes in order, buffers returned words and produces
// the extracted, zero/sign-extended result for register write-back.
//
// Ports:
//   clk, nrst                      clock (rising edge), async active-low reset
//   req_valid/req_ready            load request handshake
//   req_addr, req_size, req_signed byte address, size (00 B, 01 H, 1x W), sign
//   mem_rd_valid/mem_rd_ready      memory read command handshake
//   mem_rd_addr                    word-aligned command address
//   mem_rsp_valid, mem_rsp_data    in-order read data, no backpressure
//   out_valid/out_ready            result handshake
//   out_data, out_err              aligned result, misalignment flag
module ldalign #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  // Attribute word layout: {lane[1:0], size[1:0], signed, misaligned}
  logic [5:0]  attr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  // One read pointer serves both FIFOs because heads always pop together.
  // The data write pointer doubles as the "next load awaiting a response"
  // index into the attribute FIFO.
  logic [PW:0] attr_wr_ptr;
  logic [PW:0] data_wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] cnt;

  logic       has_credit;
  logic       accept;
  logic       pop;
  logic       rsp_push;
  logic       misaligned;
  logic [5:0] attr_in;

  logic [5:0]  head_attr;
  logic [31:0] head_data;
  logic [1:0]  head_lane;
  logic [1:0]  head_size;
  logic        head_signed;
  logic        head_mis;
  logic [31:0] shifted;
  logic [15:0] half;

  // Credits are taken from the registered count only, so a pop in the same
  // cycle never frees a slot for a new request combinationally.
  assign has_credit   = (cnt < DEPTH_C);
  assign mem_rd_valid = req_valid & has_credit;
  assign req_ready    = mem_rd_ready & has_credit;
  assign mem_rd_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign accept       = req_valid & req_ready;

  assign misaligned = ((req_size == 2'b01) & req_addr[0]) |
                      (req_size[1] & (req_addr[1:0] != 2'b00));
  assign attr_in    = {req_addr[1:0], req_size, req_signed, misaligned};

  // A response is only meaningful when some accepted load still lacks data;
  // otherwise it is stray and dropped.
  assign rsp_push  = mem_rsp_valid & (data_wr_ptr != attr_wr_ptr);
  assign out_valid = (data_wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;

  // Credit counter: one per accepted load until its result is consumed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + ONE_C;
        2'b01:   cnt <= cnt - ONE_C;
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO pointers carry one extra wrap bit and roll over naturally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      attr_wr_ptr <= '0;
      data_wr_ptr <= '0;
      rd_ptr      <= '0;
    end else begin
      if (accept) begin
        attr_wr_ptr <= attr_wr_ptr + ONE_C;
      end
      if (rsp_push) begin
        data_wr_ptr <= data_wr_ptr + ONE_C;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
    end
  end

  // Storage needs no reset: entries are only read once a pointer covers them.
  always_ff @(posedge clk) begin
    if (accept) begin
      attr_mem[attr_wr_ptr[PW-1:0]] <= attr_in;
    end
    if (rsp_push) begin
      data_mem[data_wr_ptr[PW-1:0]] <= mem_rsp_data;
    end
  end

  assign head_attr   = attr_mem[rd_ptr[PW-1:0]];
  assign head_data   = data_mem[rd_ptr[PW-1:0]];
  assign head_lane   = head_attr[5:4];
  assign head_size   = head_attr[3:2];
  assign head_signed = head_attr[1];
  assign head_mis    = head_attr[0];
  assign shifted     = head_data >> {head_lane, 3'b000};
  assign half        = head_lane[1] ? head_data[31:16] : head_data[15:0];

  // Lane extraction and extension of the head entry; outputs are held at
  // zero whenever there is no valid result.
  always_comb begin
    out_data = '0;
    out_err  = 1'b0;
    if (out_valid) begin
      if (head_mis) begin
        out_err = 1'b1;
      end else begin
        case (head_size)
          2'b00:   out_data = {{24{head_signed & shifted[7]}}, shifted[7:0]};
          2'b01:   out_data = {{16{head_signed & half[15]}}, half};
          default: out_data = head_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldalign.sv
// tb_ldalign - self-checking bench for ldalign.
//
// A behavioural memory returns random (or preloaded) words in command order
// after a configurable latency; expected results come from a byte/lane
// arithmetic model of the load rules applied to the requested address.
module tb_ldalign;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk;
  logic          nrst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic          mem_rd_valid;
  logic          mem_rd_ready;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_err;

  ldalign #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
  } load_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  load_t       exp_q[$];
  rsp_t        mem_q[$];
  logic [31:0] mem [logic [29:0]];

  int test_cnt        = 0;
  int fail_cnt        = 0;
  int cyc             = 0;
  int outstanding     = 0;
  int max_outstanding = 0;
  bit rand_lat        = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: records commands at the negedge, answers in order at posedge+1.
  initial begin
    rsp_t r;
    int   lat;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        mem_q.delete();
      end else if (mem_rd_valid && mem_rd_ready) begin
        if (!mem.exists(mem_rd_addr[31:2])) mem[mem_rd_addr[31:2]] = $urandom;
        lat = rand_lat ? int'($urandom_range(1, 3)) : 1;
        r.due  = cyc + lat;
        if (mem_q.size() > 0 && mem_q[$].due >= r.due) r.due = mem_q[$].due + 1;
        r.data = mem[mem_rd_addr[31:2]];
        mem_q.push_back(r);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  // Passive occupancy tracker: accepted loads not yet consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        outstanding = 0;
      end else begin
        if (req_valid && req_ready) outstanding++;
        if (out_valid && out_ready) outstanding--;
        if (outstanding > max_outstanding) max_outstanding = outstanding;
      end
    end
  end

  // Reference load semantics: {err, data} from the addressed word.
  function automatic logic [32:0] ref_load(input load_t ld, input logic [31:0] word);
    int unsigned     nbytes;
    int unsigned     lane;
    longint unsigned val;
    longint unsigned span;
    logic [63:0]     v;
    nbytes = (ld.size == 2'd0) ? 1 : (ld.size == 2'd1) ? 2 : 4;
    lane   = ld.addr % 4;
    if (lane % nbytes != 0) return {1'b1, 32'h0};
    span = 64'd1 << (8 * nbytes);
    val  = (64'(word) >> (8 * lane)) % span;
    if (ld.sgn && nbytes < 4 && val >= span / 2) val = val + 64'h1_0000_0000 - span;
    v = val;
    return {1'b0, v[31:0]};
  endfunction

  // Drive one request until accepted (bounded); records it for the model.
  task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                       input bit rand_rdy, output bit ok, output logic [31:0] rd_addr);
    load_t ld;
    int    waited;
    waited     = 0;
    ok         = 1'b0;
    rd_addr    = '0;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    while (!ok && waited < 200) begin
      mem_rd_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (req_valid && req_ready) begin
        ok      = 1'b1;
        rd_addr = mem_rd_addr;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    if (ok) begin
      ld.addr = addr;
      ld.size = size;
      ld.sgn  = sgn;
      exp_q.push_back(ld);
    end
  endtask

  // Wait (bounded) for one output handshake; waited counts negedges seen.
  task automatic collect(input bit rand_rdy, output bit ok, output logic [31:0] d,
                         output logic e, output int waited);
    ok     = 1'b0;
    d      = '0;
    e      = 1'b0;
    waited = 0;
    while (!ok && waited < 200) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      waited++;
      if (out_valid && out_ready) begin
        ok = 1'b1;
        d  = out_data;
        e  = out_err;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    nrst         = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_signed   = 1'b0;
    mem_rd_ready = 1'b0;
    out_ready    = 1'b0;
    #12;
    test_cnt++;
    if (out_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    test_cnt++;
    if (out_data !== 32'h0) begin fail_cnt++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    test_cnt++;
    if (out_err !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
    req_valid = 1'b1;
    #1;
    test_cnt++;
    if (mem_rd_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL reset_rd_valid_hi: got %b expected 1", mem_rd_valid); end
    test_cnt++;
    if (req_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_ready_lo: got %b expected 0", req_ready); end
    mem_rd_ready = 1'b1;
    #1;
    test_cnt++;
    if (req_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL reset_ready_hi: got %b expected 1", req_ready); end
    req_valid = 1'b0;
    #1;
    test_cnt++;
    if (mem_rd_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_rd_valid_lo: got %b expected 0", mem_rd_valid); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_signed;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    mem[30'h400] = 32'h1280_3456;
    issue(32'h1002, 2'b00, 1'b1, 1'b0, ok, ra);
    test_cnt++;
    if (!ok || ra !== 32'h1000) begin fail_cnt++; $display("[TB] FAIL byte_rd_addr: got %h (ok=%b) expected 00001000", ra, ok); end
    collect(1'b0, ok, d, e, w);
    void'(exp_q.pop_front());
    test_cnt++;
    if (!ok || d !== 32'hFFFF_FF80) begin fail_cnt++; $display("[TB] FAIL byte_data: got %h expected ffffff80", d); end
    test_cnt++;
    if (e !== 1'b0) begin fail_cnt++; $display("[TB] FAIL byte_err: got %b expected 0", e); end
    test_cnt++;
    if (w !== 2) begin fail_cnt++; $display("[TB] FAIL byte_latency: got %0d expected 2", w); end
  endtask

  task automatic test_half;
    logic [31:0] addrs [3] = '{32'h2002, 32'h2002, 32'h2000};
    logic        sgns  [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [3] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF};
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    mem[30'h800] = 32'h8001_7FFF;
    for (int i = 0; i < 3; i++) begin
      issue(addrs[i], 2'b01, sgns[i], 1'b0, ok, ra);
      collect(1'b0, ok, d, e, w);
      void'(exp_q.pop_front());
      test_cnt++;
      if (!ok || d !== exps[i] || e !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL half_%0d: got %h err %b expected %h err 0", i, d, e, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    mem[30'hC00] = 32'hDEAD_BEEF;
    issue(32'h3001, 2'b10, 1'b0, 1'b0, ok, ra);
    test_cnt++;
    if (!ok || ra !== 32'h3000) begin fail_cnt++; $display("[TB] FAIL mis_rd_addr: got %h expected 00003000", ra); end
    collect(1'b0, ok, d, e, w);
    void'(exp_q.pop_front());
    test_cnt++;
    if (!ok || e !== 1'b1 || d !== 32'h0) begin
      fail_cnt++;
      $display("[TB] FAIL mis_result: got %h err %b expected 00000000 err 1", d, e);
    end
  endtask

  task automatic test_full_backpressure;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    load_t       la;
    load_t       lb;
    load_t       lc;
    logic [32:0] ea;
    logic [32:0] eb;
    logic [32:0] ec;
    out_ready = 1'b0;
    issue(32'h5000 + 32'($urandom_range(0, 3)), 2'b00, 1'b1, 1'b0, ok, ra);
    issue(32'h5010 + 32'($urandom_range(0, 1) * 2), 2'b01, 1'b0, 1'b0, ok, ra);
    la = exp_q[0];
    lb = exp_q[1];
    lc.addr = 32'h5020;
    lc.size = 2'b10;
    lc.sgn  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = lc.addr;
    req_size   = lc.size;
    req_signed = lc.sgn;
    repeat (3) begin
      @(negedge clk);
      test_cnt++;
      if (req_ready !== 1'b0 || mem_rd_valid !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL full_block: got ready %b rd_valid %b expected 0 0", req_ready, mem_rd_valid);
      end
      @(posedge clk);
      #1;
    end
    ea = ref_load(la, mem[la.addr[31:2]]);
    eb = ref_load(lb, mem[lb.addr[31:2]]);
    @(negedge clk);
    test_cnt++;
    if (out_valid !== 1'b1 || out_data !== ea[31:0] || out_err !== ea[32]) begin
      fail_cnt++;
      $display("[TB] FAIL full_hold: got v %b %h expected v 1 %h", out_valid, out_data, ea[31:0]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    test_cnt++;
    if (req_ready !== 1'b0 || out_data !== ea[31:0]) begin
      fail_cnt++;
      $display("[TB] FAIL full_no_bypass: got ready %b data %h expected ready 0 data %h", req_ready, out_data, ea[31:0]);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    test_cnt++;
    if (req_ready !== 1'b1 || out_data !== eb[31:0] || out_err !== eb[32]) begin
      fail_cnt++;
      $display("[TB] FAIL full_second: got ready %b data %h expected ready 1 data %h", req_ready, out_data, eb[31:0]);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    collect(1'b0, ok, d, e, w);
    ec = ref_load(lc, mem.exists(lc.addr[31:2]) ? mem[lc.addr[31:2]] : 32'hX);
    test_cnt++;
    if (!ok || d !== ec[31:0] || e !== ec[32]) begin
      fail_cnt++;
      $display("[TB] FAIL full_third: got %h err %b expected %h err %b", d, e, ec[31:0], ec[32]);
    end
  endtask

  task automatic test_streaming;
    int bad_order;
    bit all_ok;
    max_outstanding = 0;
    bad_order       = 0;
    all_ok          = 1'b1;
    fork
      begin
        bit          ok;
        logic [31:0] ra;
        for (int i = 0; i < 16; i++) begin
          issue(32'h4000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00}, 2'($urandom_range(2, 3)),
                1'($urandom_range(0, 1)), 1'b0, ok, ra);
          if (!ok) all_ok = 1'b0;
        end
      end
      begin
        bit          ok;
        logic [31:0] d;
        logic        e;
        int          w;
        logic [32:0] ex;
        load_t       ld;
        for (int i = 0; i < 16; i++) begin
          collect(1'b0, ok, d, e, w);
          if (!ok || exp_q.size() == 0) begin
            all_ok = 1'b0;
          end else begin
            ld = exp_q.pop_front();
            ex = ref_load(ld, mem[ld.addr[31:2]]);
            if (d !== ex[31:0] || e !== ex[32]) begin
              bad_order++;
              $display("[TB] FAIL stream_%0d: got %h err %b expected %h err %b", i, d, e, ex[31:0], ex[32]);
            end
          end
        end
      end
    join
    test_cnt++;
    if (!all_ok || bad_order != 0) begin
      fail_cnt++;
      $display("[TB] FAIL stream_order: got %0d wrong, complete %b expected 0 wrong, complete 1", bad_order, all_ok);
    end
    test_cnt++;
    if (max_outstanding > DEPTH) begin
      fail_cnt++;
      $display("[TB] FAIL stream_credit: got %0d outstanding expected at most %0d", max_outstanding, DEPTH);
    end
  endtask

  task automatic test_random;
    int bad;
    bit all_ok;
    bad      = 0;
    all_ok   = 1'b1;
    rand_lat = 1'b1;
    fork
      begin
        bit          ok;
        logic [31:0] ra;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
          a = 32'h6000 + 32'($urandom_range(0, 63));
          issue(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, ok, ra);
          if (!ok) all_ok = 1'b0;
          else if (ra !== {a[31:2], 2'b00}) begin
            bad++;
            $display("[TB] FAIL rand_rd_addr_%0d: got %h expected %h", i, ra, {a[31:2], 2'b00});
          end
        end
      end
      begin
        bit          ok;
        logic [31:0] d;
        logic        e;
        int          w;
        logic [32:0] ex;
        load_t       ld;
        for (int i = 0; i < 40; i++) begin
          collect(1'b1, ok, d, e, w);
          if (!ok || exp_q.size() == 0) begin
            all_ok = 1'b0;
          end else begin
            ld = exp_q.pop_front();
            ex = ref_load(ld, mem[ld.addr[31:2]]);
            if (d !== ex[31:0] || e !== ex[32]) begin
              bad++;
              $display("[TB] FAIL rand_%0d: addr %h size %0d got %h err %b expected %h err %b",
                       i, ld.addr, ld.size, d, e, ex[31:0], ex[32]);
            end
          end
        end
      end
    join
    rand_lat     = 1'b0;
    mem_rd_ready = 1'b1;
    test_cnt++;
    if (!all_ok || bad != 0) begin
      fail_cnt++;
      $display("[TB] FAIL rand_summary: got %0d wrong, complete %b expected 0 wrong, complete 1", bad, all_ok);
    end
  endtask

  task automatic test_spurious_rsp;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    @(posedge clk);
    #2;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    @(negedge clk);
    test_cnt++;
    if (out_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL spurious_drop: got %b expected 0", out_valid); end
    @(posedge clk);
    #1;
    mem[30'h1C00] = 32'h0000_7F00;
    issue(32'h7001, 2'b00, 1'b1, 1'b0, ok, ra);
    collect(1'b0, ok, d, e, w);
    void'(exp_q.pop_front());
    test_cnt++;
    if (!ok || d !== 32'h0000_007F || e !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL spurious_next: got %h err %b expected 0000007f err 0", d, e);
    end
  endtask

  task automatic test_reset_midflight;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e;
    int          w;
    out_ready = 1'b0;
    issue(32'h8000, 2'b10, 1'b0, 1'b0, ok, ra);
    issue(32'h8004, 2'b10, 1'b0, 1'b0, ok, ra);
    repeat (3) @(posedge clk);
    #1;
    test_cnt++;
    if (out_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL midrst_pre: got %b expected 1", out_valid); end
    @(negedge clk);
    #2;
    nrst         = 1'b0;
    mem_rd_ready = 1'b1;
    #1;
    test_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL midrst_out: got v %b %h err %b expected v 0 00000000 err 0", out_valid, out_data, out_err);
    end
    test_cnt++;
    if (req_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL midrst_ready_hi: got %b expected 1", req_ready); end
    mem_rd_ready = 1'b0;
    #1;
    test_cnt++;
    if (req_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midrst_ready_lo: got %b expected 0", req_ready); end
    mem_rd_ready = 1'b1;
    @(negedge clk);
    #2;
    nrst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    mem[30'h2400] = 32'h00C3_0000;
    issue(32'h9002, 2'b00, 1'b0, 1'b0, ok, ra);
    collect(1'b0, ok, d, e, w);
    void'(exp_q.pop_front());
    test_cnt++;
    if (!ok || d !== 32'h0000_00C3 || e !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL midrst_fresh: got %h err %b expected 000000c3 err 0", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_half();
    test_misaligned();
    test_full_backpressure();
    test_streaming();
    test_random();
    test_spurious_rsp();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
